// File: rtl/cic_comb.sv
// ============================================================================
// cic_comb : CIC decimator comb section (CIC_N combs, differential delay CIC_M)
//            followed by round-half-up / saturate reduction to the output width.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cic_comb #(
  parameter int DATA_WIDTH_INP = 20,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int CIC_N          = 3,
  parameter int CIC_M          = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [DATA_WIDTH_INP-1:0] s_axis_in_tdata,
  input  logic                             s_axis_in_tvalid,
  output logic signed [DATA_WIDTH_OUT-1:0] m_axis_out_tdata,
  output logic                             m_axis_out_tvalid
);

  localparam int SH = DATA_WIDTH_INP - DATA_WIDTH_OUT;

  // Each stage advances only on a valid input, so the response ignores gaps.
  for (genvar k = 1; k <= CIC_N; k++) begin : g_stage
    logic signed [DATA_WIDTH_INP-1:0] data;
    logic                             valid;
    logic signed [DATA_WIDTH_INP-1:0] dly [CIC_M];
    logic signed [DATA_WIDTH_INP-1:0] in_data;
    logic                             in_valid;

    if (k == 1) begin : g_head
      assign in_data  = s_axis_in_tdata;
      assign in_valid = s_axis_in_tvalid;
    end else begin : g_link
      assign in_data  = g_stage[k-1].data;
      assign in_valid = g_stage[k-1].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data  <= '0;
        valid <= 1'b0;
        for (int j = 0; j < CIC_M; j++) begin
          dly[j] <= '0;
        end
      end else begin
        valid <= in_valid;
        if (in_valid) begin
          data   <= in_data - dly[CIC_M-1];
          dly[0] <= in_data;
          for (int j = CIC_M - 1; j > 0; j--) begin
            dly[j] <= dly[j-1];
          end
        end
      end
    end
  end

  logic signed [DATA_WIDTH_INP-1:0] last_data;
  logic                             last_valid;
  logic signed [DATA_WIDTH_OUT-1:0] out_next;

  assign last_data  = g_stage[CIC_N].data;
  assign last_valid = g_stage[CIC_N].valid;

  if (SH == 0) begin : g_pass
    assign out_next = last_data;
  end else begin : g_round
    // One guard bit keeps the rounding addend from wrapping near full scale.
    localparam logic signed [DATA_WIDTH_INP:0] HALF =
      (DATA_WIDTH_INP+1)'(1) << (SH - 1);
    localparam logic signed [DATA_WIDTH_INP:0] SAT_MAX =
      (DATA_WIDTH_INP+1)'((1 << (DATA_WIDTH_OUT - 1)) - 1);
    localparam logic signed [DATA_WIDTH_INP:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_WIDTH_INP:0] sum;
    logic signed [DATA_WIDTH_INP:0] shifted;

    always_comb begin
      sum     = {last_data[DATA_WIDTH_INP-1], last_data} + HALF;
      shifted = sum >>> SH;
      if (shifted > SAT_MAX) begin
        out_next = SAT_MAX[DATA_WIDTH_OUT-1:0];
      end else if (shifted < SAT_MIN) begin
        out_next = SAT_MIN[DATA_WIDTH_OUT-1:0];
      end else begin
        out_next = shifted[DATA_WIDTH_OUT-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
    end else begin
      m_axis_out_tvalid <= last_valid;
      if (last_valid) begin
        m_axis_out_tdata <= out_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cic_comb.sv
// ============================================================================
// tb_cic_comb : scoreboard bench for cic_comb (default build and M=2/SH=0 build)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cic_comb;

  typedef struct {
    logic signed [19:0] data;
    int                 cyc;
  } exp_t;

  logic               clk;
  logic               reset;
  logic signed [19:0] in_data;
  logic               in_valid;
  logic signed [15:0] out1;
  logic               v1;
  logic signed [19:0] out2;
  logic               v2;

  int checks;
  int errors;
  int cyc;

  exp_t               q1[$];
  exp_t               q2[$];
  logic signed [15:0] obs1[$];
  logic signed [19:0] obs2[$];
  logic signed [15:0] last1;
  logic signed [19:0] last2;
  longint             hist [0:7];

  cic_comb #(
    .DATA_WIDTH_INP(20), .DATA_WIDTH_OUT(16), .CIC_N(3), .CIC_M(1)
  ) dut1 (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
    .m_axis_out_tdata(out1), .m_axis_out_tvalid(v1)
  );

  cic_comb #(
    .DATA_WIDTH_INP(20), .DATA_WIDTH_OUT(20), .CIC_N(3), .CIC_M(2)
  ) dut2 (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
    .m_axis_out_tdata(out2), .m_axis_out_tvalid(v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Direct-form reference: y = sum_i (-1)^i C(3,i) x[n-i*m], wrapped to 20 bits.
  function automatic logic signed [19:0] model(input int m, input int sh, input int wout);
    longint acc;
    longint c;
    longint lim;
    acc = 0;
    c   = 1;
    for (int i = 0; i <= 3; i++) begin
      acc = acc + (((i % 2) == 1) ? -c : c) * hist[i*m];
      c   = c * (3 - i) / (i + 1);
    end
    acc = acc & longint'(20'hFFFFF);
    if (acc >= 524288) acc = acc - 1048576;
    if (sh > 0) begin
      acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
      lim = longint'(1) << (wout - 1);
      if (acc > lim - 1) acc = lim - 1;
      if (acc < -lim) acc = -lim;
    end
    return acc[19:0];
  endfunction

  task automatic clear_model();
    q1.delete();
    q2.delete();
    obs1.delete();
    obs2.delete();
    last1 = '0;
    last2 = '0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
  endtask

  task automatic drive(input logic v, input longint x);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = x[19:0];
    if (v) begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
      e.cyc  = cyc + 4;
      e.data = model(1, 4, 16);
      q1.push_back(e);
      e.data = model(2, 0, 20);
      q2.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q1.size() > 0 || q2.size() > 0); i++) drive(1'b0, 0);
    drive(1'b0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clear_model();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checks++;
        if (v1) begin
          obs1.push_back(out1);
          last1 = out1;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb1_stray cyc=%0d got valid data=%0d, expected no output", cyc, out1);
          end else begin
            e = q1.pop_front();
            if (out1 !== e.data[15:0] || cyc != e.cyc) begin
              errors++;
              $display("FAIL sb1_data cyc=%0d got %0d, expected %0d at cyc %0d",
                       cyc, out1, $signed(e.data[15:0]), e.cyc);
            end
          end
        end else if (out1 !== last1) begin
          errors++;
          $display("FAIL sb1_hold cyc=%0d got %0d, expected held %0d", cyc, out1, last1);
        end
        checks++;
        if (v2) begin
          obs2.push_back(out2);
          last2 = out2;
          if (q2.size() == 0) begin
            errors++;
            $display("FAIL sb2_stray cyc=%0d got valid data=%0d, expected no output", cyc, out2);
          end else begin
            e = q2.pop_front();
            if (out2 !== e.data || cyc != e.cyc) begin
              errors++;
              $display("FAIL sb2_data cyc=%0d got %0d, expected %0d at cyc %0d",
                       cyc, out2, e.data, e.cyc);
            end
          end
        end else if (out2 !== last2) begin
          errors++;
          $display("FAIL sb2_hold cyc=%0d got %0d, expected held %0d", cyc, out2, last2);
        end
        if (q1.size() > 0 && q1[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL sb1_missing expected %0d at cyc %0d, got none", $signed(q1[0].data[15:0]), q1[0].cyc);
          void'(q1.pop_front());
        end
        if (q2.size() > 0 && q2[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL sb2_missing expected %0d at cyc %0d, got none", q2[0].data, q2[0].cyc);
          void'(q2.pop_front());
        end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (out1 !== 16'sd0 || v1 !== 1'b0 || out2 !== 20'sd0 || v2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %0d/%0b %0d/%0b, expected 0/0 0/0", out1, v1, out2, v2);
    end
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_impulse();
    int exp_v [5] = '{1, -3, 3, -1, 0};
    do_reset();
    drive(1'b1, 16);
    for (int i = 0; i < 8; i++) drive(1'b1, 0);
    drain();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs1.size() || obs1[i] !== 16'(exp_v[i])) begin
        errors++;
        $display("FAIL impulse[%0d] got %0d, expected %0d", i, obs1[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_step_gaps();
    int exp_v [6] = '{10, -20, 10, 0, 0, 0};
    do_reset();
    for (int s = 0; s < 6; s++) begin
      drive(1'b1, 160);
      repeat (3) drive(1'b0, 0);
    end
    drain();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= obs1.size() || obs1[i] !== 16'(exp_v[i])) begin
        errors++;
        $display("FAIL step_gaps[%0d] got %0d, expected %0d", i, obs1[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_rounding();
    int in_v  [4] = '{8, -8, 7, -9};
    int exp_v [4] = '{1, 0, 0, -1};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      drive(1'b1, longint'(in_v[t]));
      repeat (4) drive(1'b1, 0);
      drain();
      checks++;
      if (obs1.size() == 0 || obs1[0] !== 16'(exp_v[t])) begin
        errors++;
        $display("FAIL rounding(%0d) got %0d, expected %0d", in_v[t], obs1[0], exp_v[t]);
      end
    end
  endtask

  task automatic test_sat_wrap();
    do_reset();
    drive(1'b1, 524287);
    drive(1'b1, -524288);
    drive(1'b0, 0);
    checks++;
    if (dut1.g_stage[1].data !== 20'sd1) begin
      errors++;
      $display("FAIL stage1_wrap got %0d, expected 1", dut1.g_stage[1].data);
    end
    repeat (4) drive(1'b1, 0);
    drain();
    checks++;
    if (obs1.size() == 0 || obs1[0] !== 16'sd32767) begin
      errors++;
      $display("FAIL saturate got %0d, expected 32767", obs1[0]);
    end
  endtask

  task automatic test_reset_midstream();
    int exp_v [4] = '{1, -3, 3, -1};
    do_reset();
    repeat (5) drive(1'b1, 1600);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clear_model();
    #1;
    checks++;
    if (out1 !== 16'sd0 || v1 !== 1'b0 || out2 !== 20'sd0 || v2 !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset got %0d/%0b %0d/%0b, expected 0/0 0/0", out1, v1, out2, v2);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (6) drive(1'b0, 0);
    drive(1'b1, 16);
    repeat (6) drive(1'b1, 0);
    drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs1.size() || obs1[i] !== 16'(exp_v[i])) begin
        errors++;
        $display("FAIL post_reset_impulse[%0d] got %0d, expected %0d", i, obs1[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_m2_sh0();
    int exp_v [8] = '{5, 0, -15, 0, 15, 0, -5, 0};
    do_reset();
    drive(1'b1, 5);
    repeat (10) drive(1'b1, 0);
    drain();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= obs2.size() || obs2[i] !== 20'(exp_v[i])) begin
        errors++;
        $display("FAIL m2_impulse[%0d] got %0d, expected %0d", i, obs2[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [19:0] r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = 20'($urandom);
      if (i % 50 < 20) drive(1'b1, longint'(r));
      else drive($urandom_range(0, 2) != 0, longint'(r));
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clear_model();
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_impulse();
    test_step_gaps();
    test_rounding();
    test_sat_wrap();
    test_reset_midstream();
    test_m2_sh0();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
